// File: rtl/rr_run_sched.sv
// rr_run_sched
// ------------
// Round-robin scheduler that time-shares one serial run-of-ones detector
// among N_REQ frame sources. The winner's FRAME_LEN-bit frame is shifted
// LSB-first through the detector. The result reports whether RUN_LEN or more
// consecutive ones occurred, and the bit index at which the run first
// completed.
//
// Optional feature (compile-time macro):
//   RR_RUN_SCHED_EARLY_TERM_EN - when defined, SHIFT ends in the cycle after
//   the first hit, so done arrives at t+3+hit_pos. When undefined, all
//   FRAME_LEN bits are always shifted, giving a fixed latency of FRAME_LEN+2.
//   hit and hit_pos are identical either way.
//
// Ports:
//   clk        - rising-edge clock
//   reset      - synchronous, active-low reset
//   req        - per-requester request, held until done (or withdrawn = abort)
//   frame_data - requester i's frame in [i*FRAME_LEN +: FRAME_LEN]
//   grant      - one-hot grant, high from LOAD through REPORT
//   busy       - high whenever the FSM is not in IDLE
//   done       - one-cycle pulse in REPORT
//   done_id    - index of the reported requester (0 when done=0)
//   hit        - run found (0 when done=0)
//   hit_pos    - bit index where the run count first reached RUN_LEN
//   abort      - frame abandoned because req was withdrawn (0 when done=0)
//   state_dbg  - FSM state: 0=IDLE 1=LOAD 2=SHIFT 3=REPORT
//
// Handshake: a requester raises req[i] with a stable frame. The request is
// accepted when grant[i] rises (LOAD). The transaction completes on the single
// cycle where done=1 with done_id=i. The requester must then drop req[i]. If
// req[i] drops while granted and before REPORT, the frame is aborted.
module rr_run_sched #(
    parameter int N_REQ     = 4,
    parameter int FRAME_LEN = 8,
    parameter int RUN_LEN   = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_REQ-1:0]             req,
    input  logic [N_REQ*FRAME_LEN-1:0]   frame_data,
    output logic [N_REQ-1:0]             grant,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(N_REQ)-1:0]     done_id,
    output logic                         hit,
    output logic [$clog2(FRAME_LEN)-1:0] hit_pos,
    output logic                         abort,
    output logic [1:0]                   state_dbg
);
    localparam int IDW = $clog2(N_REQ);
    localparam int PW  = $clog2(FRAME_LEN);
    localparam int CW  = $clog2(RUN_LEN + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_SHIFT  = 2'd2,
        S_REPORT = 2'd3
    } state_t;

    state_t               state, state_nxt;
    logic [IDW-1:0]       ptr, winner, pick, cand;
    logic                 pick_vld;
    logic [FRAME_LEN-1:0] sreg;
    logic [PW-1:0]        idx, pos_r;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic                 hit_r, abort_r;
    logic                 first_hit, last_bit, req_lost;

    // Round-robin pick. The loop scans offsets from high to low so that the
    // smallest offset from ptr, which is the highest priority, is written last.
    always_comb begin
        pick     = ptr;
        pick_vld = 1'b0;
        cand     = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = IDW'((int'(ptr) + i) % N_REQ);
            if (req[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    // Run counter saturates at RUN_LEN. This makes "reached RUN_LEN" a simple
    // equality, and first_hit fires only once because hit_r is sticky.
    always_comb begin
        if (sreg[0]) begin
            cnt_nxt = (cnt == CW'(RUN_LEN)) ? cnt : cnt + CW'(1);
        end else begin
            cnt_nxt = '0;
        end
        first_hit = !hit_r && (cnt_nxt == CW'(RUN_LEN));
        last_bit  = (idx == PW'(FRAME_LEN - 1));
        req_lost  = !req[winner];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (pick_vld) state_nxt = S_LOAD;
            S_LOAD:   state_nxt = S_SHIFT;
            S_SHIFT: begin
                if (req_lost || last_bit) state_nxt = S_REPORT;
`ifdef RR_RUN_SCHED_EARLY_TERM_EN
                if (first_hit) state_nxt = S_REPORT;
`endif
            end
            S_REPORT: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            ptr     <= '0;
            winner  <= '0;
            sreg    <= '0;
            idx     <= '0;
            cnt     <= '0;
            hit_r   <= 1'b0;
            pos_r   <= '0;
            abort_r <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (pick_vld) winner <= pick;
                end
                S_LOAD: begin
                    sreg    <= frame_data[int'(winner)*FRAME_LEN +: FRAME_LEN];
                    idx     <= '0;
                    cnt     <= '0;
                    hit_r   <= 1'b0;
                    pos_r   <= '0;
                    abort_r <= 1'b0;
                end
                S_SHIFT: begin
                    // A withdrawn request wins over the bit in flight. The
                    // partial result is discarded.
                    if (req_lost) begin
                        abort_r <= 1'b1;
                        hit_r   <= 1'b0;
                        pos_r   <= '0;
                    end else begin
                        sreg <= sreg >> 1;
                        idx  <= idx + PW'(1);
                        cnt  <= cnt_nxt;
                        if (first_hit) begin
                            hit_r <= 1'b1;
                            pos_r <= idx;
                        end
                    end
                end
                S_REPORT: begin
                    ptr <= (int'(winner) == N_REQ - 1) ? '0 : winner + IDW'(1);
                end
                default: ;
            endcase
        end
    end

    // Result fields are gated with done so they read 0 outside REPORT.
    always_comb begin
        busy      = (state != S_IDLE);
        done      = (state == S_REPORT);
        grant     = busy ? (N_REQ'(1) << winner) : '0;
        done_id   = done ? winner : '0;
        hit       = done & hit_r;
        hit_pos   = done ? pos_r : '0;
        abort     = done & abort_r;
        state_dbg = state;
    end
endmodule

// File: tb/tb_rr_run_sched.sv
`timescale 1ns/1ps
module tb_rr_run_sched;
    localparam int N_REQ     = 4;
    localparam int FRAME_LEN = 8;
    localparam int RUN_LEN   = 2;
    localparam int IDW       = $clog2(N_REQ);
    localparam int PW        = $clog2(FRAME_LEN);
    localparam int W         = 2 + PW + IDW;
`ifdef RR_RUN_SCHED_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [N_REQ-1:0]           req = '0;
    logic [FRAME_LEN-1:0]       frames [N_REQ];
    logic [N_REQ*FRAME_LEN-1:0] frame_data;
    logic [N_REQ-1:0]           grant;
    logic                       busy, done, hit, abort;
    logic [IDW-1:0]             done_id;
    logic [PW-1:0]              hit_pos;
    logic [1:0]                 state_dbg;

    always_comb begin
        frame_data = '0;
        for (int i = 0; i < N_REQ; i++) frame_data[i*FRAME_LEN +: FRAME_LEN] = frames[i];
    end

    rr_run_sched #(.N_REQ(N_REQ), .FRAME_LEN(FRAME_LEN), .RUN_LEN(RUN_LEN)) dut (
        .clk(clk), .reset(reset), .req(req), .frame_data(frame_data),
        .grant(grant), .busy(busy), .done(done), .done_id(done_id),
        .hit(hit), .hit_pos(hit_pos), .abort(abort), .state_dbg(state_dbg)
    );

    // ---------------- scoreboard / model ----------------
    int checks = 0;
    int errors = 0;
    int ptr_m  = 0;
    logic [W-1:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scans the frame and returns the first index at which RUN_LEN
    // consecutive ones have been seen.
    function automatic void ref_run(input logic [FRAME_LEN-1:0] f, output bit h, output int pos);
        int run;
        run = 0; h = 0; pos = 0;
        for (int i = 0; i < FRAME_LEN; i++) begin
            run = f[i] ? run + 1 : 0;
            if (!h && run >= RUN_LEN) begin
                h = 1; pos = i;
            end
        end
    endfunction

    function automatic int ref_pick(input logic [N_REQ-1:0] r, input int p);
        for (int i = 0; i < N_REQ; i++) begin
            int c;
            c = (p + i) % N_REQ;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in an IDLE cycle. Presents r and predicts winner, result and
    // latency. abort_at=k withdraws the winner's req during cycle t+k.
    task automatic run_req(input logic [N_REQ-1:0] r, input int abort_at);
        int win, pos, lat_exp, lat, last_shift;
        bit h, ab, seen;
        logic [W-1:0] e;
        check("idle_before_req", busy, 0);
        req = r;
        win = ref_pick(r, ptr_m);
        ref_run(frames[win], h, pos);
        last_shift = (EARLY && h) ? 2 + pos : FRAME_LEN + 1;
        if (abort_at >= 2 && abort_at <= last_shift) begin
            ab = 1; h = 0; pos = 0; lat_exp = abort_at + 1;
        end else begin
            ab = 0; lat_exp = last_shift + 1;
        end
        exp_q.push_back({ab, h, PW'(pos), IDW'(win)});
        seen = 0; lat = 0;
        for (int s = 1; s <= FRAME_LEN + 10 && !seen; s++) begin
            step();
            if (s == 1) check("grant_at_load", grant, 32'(1) << win);
            if (s == abort_at) req[win] = 1'b0;
            if (done) begin
                seen = 1; lat = s;
            end
        end
        check("done_seen", seen, 1);
        e = exp_q.pop_front();
        if (seen) begin
            check("latency", lat, lat_exp);
            check("done_id", done_id, e[IDW-1:0]);
            check("hit", hit, e[W-2]);
            check("hit_pos", hit_pos, e[IDW +: PW]);
            check("abort", abort, e[W-1]);
            check("grant_at_report", grant, 32'(1) << win);
        end
        ptr_m = (win + 1) % N_REQ;
        req[win] = 1'b0;
        step();
        check("done_one_cycle", done, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit got_done;
        for (int i = 0; i < N_REQ; i++) frames[i] = '0;
        reset = 1'b0;
        repeat (3) step();
        check("rst_busy", busy, 0);
        check("rst_grant", grant, 0);
        check("rst_done", done, 0);
        check("rst_state", state_dbg, 0);
        reset = 1'b1;
        step();

        // Single requester with a hit at bit 2.
        frames[0] = 8'b0000_0110;
        run_req(4'b0001, -1);
        // Alternating bits never form a run.
        frames[2] = 8'b0101_0101;
        run_req(4'b0100, -1);

        // Reset in the middle of a frame discards it silently.
        frames[0] = 8'b1111_0000;
        check("pre_reset_idle", busy, 0);
        req = 4'b0001;
        repeat (5) step();
        reset = 1'b0;
        step();
        check("midrst_grant", grant, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_done_id", done_id, 0);
        check("midrst_hit", hit, 0);
        check("midrst_hit_pos", hit_pos, 0);
        check("midrst_abort", abort, 0);
        check("midrst_state", state_dbg, 0);
        reset = 1'b1;
        req = '0;
        ptr_m = 0;
        got_done = 0;
        repeat (FRAME_LEN + 6) begin
            step();
            if (done) got_done = 1;
        end
        check("no_done_after_reset", got_done, 0);

        // All four requesting. Each drops only after its own done.
        for (int i = 0; i < N_REQ; i++) frames[i] = 8'($urandom_range(0, 255));
        run_req(4'b1111, -1);
        for (int k = 0; k < N_REQ - 1; k++) run_req(req, -1);
        req = '0;
        step();
        run_req(4'b1001, -1);

        // Withdrawn request during SHIFT.
        frames[1] = 8'b1111_1111;
        run_req(4'b0010, 4);

        // Run completing at bit 1 (early-termination case when enabled).
        frames[0] = 8'b0000_0011;
        run_req(4'b0001, -1);

        // Randomized traffic, including aborts and the last-bit boundary.
        for (int it = 0; it < 40; it++) begin
            logic [N_REQ-1:0] r;
            int ab_at;
            req = '0;
            for (int i = 0; i < N_REQ; i++) frames[i] = 8'($urandom_range(0, 255));
            step();
            r = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
            ab_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, FRAME_LEN + 1)) : -1;
            run_req(r, ab_at);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end
endmodule
